// File: rtl/rpt_log_reader.sv
// Report-record consumer: per-type saturating counters, info/main log routing, STOP/EXIT handling
// and a four-beat counter summary. Define RPT_LOG_READER_TIMESTAMP_EN to add the log_ts port.
module rpt_log_reader #(
    parameter int SRC_W = 8,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [1:0]       rec_type,
    input  logic [1:0]       rec_sev,
    input  logic [1:0]       rec_act,
    input  logic [SRC_W-1:0] rec_src,
    input  logic [1:0]       cfg_svrt,
    input  logic [1:0]       cfg_errty,
    output logic             log_valid,
    input  logic             log_ready,
    output logic             log_chan,
    output logic             log_err,
    output logic [1:0]       log_type,
    output logic [1:0]       log_sev,
    output logic [SRC_W-1:0] log_src,
`ifdef RPT_LOG_READER_TIMESTAMP_EN
    output logic [TS_W-1:0]  log_ts,
`endif
    output logic             halted,
    output logic             done,
    input  logic             resume,
    input  logic             clr,
    input  logic             sum_req,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sum_last,
    output logic [CNT_W-1:0] sum_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_HALT = 3'd2;
    localparam logic [2:0] S_SUM  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] ACT_STOP = 2'd1;
    localparam logic [1:0] ACT_EXIT = 2'd2;

    logic [2:0]       state;
    logic [1:0]       act;
    logic [1:0]       beat;
    logic             sum_from_done;
    logic [CNT_W-1:0] cnt  [0:3];
    logic [CNT_W-1:0] snap [0:3];
    logic             accept;
    logic             sum_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign rec_ready = (state == S_IDLE) && !sum_req;
    assign accept    = rec_valid && rec_ready;
    assign log_valid = (state == S_FWD);
    assign halted    = (state == S_HALT);
    assign done      = (state == S_DONE);
    assign sum_valid = (state == S_SUM);
    assign sum_last  = (state == S_SUM) && (beat == 2'd3);
    assign sum_data  = snap[beat];
    assign sum_done  = sum_last && sum_ready;

    // Control FSM, record capture and summary snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            act           <= 2'd0;
            beat          <= 2'd0;
            sum_from_done <= 1'b0;
            log_chan      <= 1'b0;
            log_err       <= 1'b0;
            log_type      <= 2'd0;
            log_sev       <= 2'd0;
            log_src       <= {SRC_W{1'b0}};
            for (int i = 0; i < 4; i++) begin
                snap[i] <= {CNT_W{1'b0}};
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (sum_req) begin
                        state         <= S_SUM;
                        beat          <= 2'd0;
                        sum_from_done <= 1'b0;
                        snap          <= cnt;
                    end else if (rec_valid) begin
                        state    <= S_FWD;
                        act      <= rec_act;
                        log_type <= rec_type;
                        log_sev  <= rec_sev;
                        log_src  <= rec_src;
                        log_chan <= (rec_sev >= cfg_svrt);
                        log_err  <= (rec_sev >= cfg_svrt) && (rec_type >= cfg_errty);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FWD: begin
                    // Actions only take effect for records routed to the main log.
                    if (log_ready) begin
                        if (log_chan && (act == ACT_STOP)) begin
                            state <= S_HALT;
                        end else if (log_chan && (act == ACT_EXIT)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        state <= S_FWD;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_HALT;
                    end
                end
                S_SUM: begin
                    if (sum_ready) begin
                        if (beat == 2'd3) begin
                            state <= sum_from_done ? S_DONE : S_IDLE;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end else begin
                        state <= S_SUM;
                    end
                end
                S_DONE: begin
                    if (sum_req) begin
                        state         <= S_SUM;
                        beat          <= 2'd0;
                        sum_from_done <= 1'b1;
                        snap          <= cnt;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Live per-type counters; clr overrides any increment, and the summary counts as one INFO record.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (accept) begin
            cnt[rec_type] <= sat_inc(cnt[rec_type]);
        end else if (sum_done) begin
            cnt[0] <= sat_inc(cnt[0]);
        end else begin
            cnt <= cnt;
        end
    end

`ifdef RPT_LOG_READER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running cycle counter, captured with each accepted record.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= {TS_W{1'b0}};
            log_ts <= {TS_W{1'b0}};
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (accept) begin
                log_ts <= ts_cnt;
            end else begin
                log_ts <= log_ts;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rpt_log_reader.sv
// Scoreboard bench for rpt_log_reader: directed records and summaries, plus a CNT_W=2 instance for saturation.
module tb_rpt_log_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_valid = 1'b0, rec_ready;
    logic [1:0]  rec_type = 2'd0, rec_sev = 2'd0, rec_act = 2'd0;
    logic [7:0]  rec_src = 8'd0;
    logic [1:0]  cfg_svrt = 2'd1, cfg_errty = 2'd2;
    logic        log_valid, log_ready = 1'b1, log_chan, log_err;
    logic [1:0]  log_type, log_sev;
    logic [7:0]  log_src;
    logic        halted, done, resume = 1'b0, clr = 1'b0, sum_req = 1'b0;
    logic        sum_valid, sum_ready = 1'b0, sum_last;
    logic [15:0] sum_data;
`ifdef RPT_LOG_READER_TIMESTAMP_EN
    logic [31:0] log_ts;
    logic [31:0] s_log_ts;
`endif

    logic        s_rec_valid = 1'b0, s_rec_ready;
    logic        s_log_valid, s_log_chan, s_log_err, s_halted, s_done;
    logic [1:0]  s_log_type, s_log_sev;
    logic [7:0]  s_log_src;
    logic        s_sum_req = 1'b0, s_sum_valid, s_sum_last;
    logic [1:0]  s_sum_data;

    int errors = 0;
    int checks = 0;

    logic [13:0] log_q [$];
    logic [16:0] sum_q [$];
    logic [2:0]  s_sum_q [$];

    always #5 clk = ~clk;

    rpt_log_reader #(.SRC_W(8), .CNT_W(16), .TS_W(32)) dut (
        .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_type(rec_type), .rec_sev(rec_sev), .rec_act(rec_act), .rec_src(rec_src),
        .cfg_svrt(cfg_svrt), .cfg_errty(cfg_errty), .log_valid(log_valid), .log_ready(log_ready),
        .log_chan(log_chan), .log_err(log_err), .log_type(log_type), .log_sev(log_sev),
        .log_src(log_src),
`ifdef RPT_LOG_READER_TIMESTAMP_EN
        .log_ts(log_ts),
`endif
        .halted(halted), .done(done), .resume(resume), .clr(clr), .sum_req(sum_req),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_last(sum_last), .sum_data(sum_data)
    );

    rpt_log_reader #(.SRC_W(8), .CNT_W(2), .TS_W(32)) dut_small (
        .clk(clk), .rst(rst), .rec_valid(s_rec_valid), .rec_ready(s_rec_ready),
        .rec_type(2'd1), .rec_sev(2'd0), .rec_act(2'd0), .rec_src(8'h5A),
        .cfg_svrt(2'd0), .cfg_errty(2'd0), .log_valid(s_log_valid), .log_ready(1'b1),
        .log_chan(s_log_chan), .log_err(s_log_err), .log_type(s_log_type), .log_sev(s_log_sev),
        .log_src(s_log_src),
`ifdef RPT_LOG_READER_TIMESTAMP_EN
        .log_ts(s_log_ts),
`endif
        .halted(s_halted), .done(s_done), .resume(1'b0), .clr(1'b0), .sum_req(s_sum_req),
        .sum_valid(s_sum_valid), .sum_ready(1'b1), .sum_last(s_sum_last), .sum_data(s_sum_data)
    );

    task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        end
    endtask

    // Monitor: pops expected beats/records whenever a handshake is about to complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (log_valid && log_ready) begin
                if (log_q.size() == 0) check("log_unexpected", 32'd1, 32'd0);
                else check("log_record", 32'({log_chan, log_err, log_type, log_sev, log_src}),
                           32'(log_q.pop_front()));
            end
            if (sum_valid && sum_ready) begin
                if (sum_q.size() == 0) check("sum_unexpected", 32'd1, 32'd0);
                else check("sum_beat", 32'({sum_last, sum_data}), 32'(sum_q.pop_front()));
            end
            if (s_sum_valid) begin
                if (s_sum_q.size() == 0) check("small_sum_unexpected", 32'd1, 32'd0);
                else check("small_sum_beat", 32'({s_sum_last, s_sum_data}), 32'(s_sum_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [1:0] s, input logic [1:0] a,
                        input logic [7:0] src, input logic exp_chan, input logic exp_err,
                        input logic with_clr);
        int n = 0;
        while (!rec_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready_wait", 32'(rec_ready), 32'd1);
        rec_valid = 1'b1;
        rec_type  = t;
        rec_sev   = s;
        rec_act   = a;
        rec_src   = src;
        clr       = with_clr;
        log_q.push_back({exp_chan, exp_err, t, s, src});
        tick();
        rec_valid = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic do_sum(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
        int n = 0;
        sum_q.push_back({1'b0, e0});
        sum_q.push_back({1'b0, e1});
        sum_q.push_back({1'b0, e2});
        sum_q.push_back({1'b1, e3});
        sum_req = 1'b1;
        tick();
        sum_req = 1'b0;
        while (sum_q.size() != 0 && n < 60) begin
            sum_ready = ~sum_ready;
            tick();
            n++;
        end
        sum_ready = 1'b0;
        check("sum_complete", 32'(sum_q.size()), 32'd0);
        sum_q.delete();
        tick();
    endtask

    task automatic small_sum(input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input logic [1:0] e3);
        int n = 0;
        s_sum_q.push_back({1'b0, e0});
        s_sum_q.push_back({1'b0, e1});
        s_sum_q.push_back({1'b0, e2});
        s_sum_q.push_back({1'b1, e3});
        s_sum_req = 1'b1;
        tick();
        s_sum_req = 1'b0;
        while (s_sum_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check("small_sum_complete", 32'(s_sum_q.size()), 32'd0);
        s_sum_q.delete();
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_rec_ready", 32'(rec_ready), 32'd1);
        check("rst_outputs", 32'({log_valid, log_chan, log_err, halted, done, sum_valid, sum_last}), 32'd0);
        check("rst_sum_data", 32'(sum_data), 32'd0);

        // Saturating counters with CNT_W=2: five WARNINGs read back as 3.
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (!s_rec_ready && n < 20) begin
                tick();
                n++;
            end
            s_rec_valid = 1'b1;
            tick();
            s_rec_valid = 1'b0;
        end
        tick();
        small_sum(2'd0, 2'd3, 2'd0, 2'd0);
        small_sum(2'd1, 2'd3, 2'd0, 2'd0);

        // ERROR/HIGH with svrt=MEDIUM, errty=ERROR: main + error log, one-cycle ready drop.
        send(2'd2, 2'd2, 2'd0, 8'h11, 1'b1, 1'b1, 1'b0);
        check("accept_ready_low", 32'(rec_ready), 32'd0);
        tick();
        check("ready_after_fwd", 32'(rec_ready), 32'd1);

        // WARNING/LOW with STOP: info log only, action ignored.
        send(2'd1, 2'd0, 2'd1, 8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("low_sev_no_halt", 32'({halted, rec_ready}), 32'b01);

        // INFO/TOP with STOP and a stalled sink.
        log_ready = 1'b0;
        send(2'd0, 2'd3, 2'd1, 8'h33, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", 32'({log_valid, log_chan, log_type, log_sev, log_src}), 32'({1'b1, 1'b1, 2'd0, 2'd3, 8'h33}));
            check("stall_no_halt", 32'(halted), 32'd0);
            tick();
        end
        log_ready = 1'b1;
        tick();
        check("halted_after_hs", 32'({halted, rec_ready}), 32'b10);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resumed", 32'({halted, rec_ready}), 32'b01);

        do_sum(16'd1, 16'd1, 16'd1, 16'd0);

        // clr coincident with an accept: nothing counted, record still forwarded.
        send(2'd3, 2'd1, 2'd0, 8'h44, 1'b1, 1'b1, 1'b1);
        tick();
        do_sum(16'd0, 16'd0, 16'd0, 16'd0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(2'd0, 2'd0, 2'd0, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        send(2'd3, 2'd3, 2'd0, 8'h60, 1'b1, 1'b1, 1'b0);
        tick();
        do_sum(16'd3, 16'd0, 16'd0, 16'd1);
        do_sum(16'd4, 16'd0, 16'd0, 16'd1);

        // EXIT on the main log, then a summary out of DONE returns to DONE.
        send(2'd0, 2'd2, 2'd2, 8'h77, 1'b1, 1'b0, 1'b0);
        tick();
        check("done_state", 32'({done, rec_ready}), 32'b10);
        do_sum(16'd6, 16'd0, 16'd0, 16'd1);
        check("done_after_sum", 32'({done, rec_ready}), 32'b10);

        // Reset in the middle of a summary.
        sum_req = 1'b1;
        tick();
        sum_req = 1'b0;
        check("sum_started", 32'(sum_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_sum", 32'({sum_valid, done, rec_ready}), 32'b001);
        rst = 1'b0;
        tick();

        check("log_q_drained", 32'(log_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
